// File: rtl/sysbus_nslave.sv
// Single-master data bus: decodes the master address into one of NSLAVE regions, forwards the
// access with a request/ready handshake and returns read data, with an error on decode miss or timeout.
module sysbus_nslave #(
  parameter int WIDTH      = 32,
  parameter int NSLAVE     = 4,
  parameter int REGIONBITS = 20,
  parameter int TIMEOUT    = 15
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    mreq,
  input  logic                    mwrite,
  input  logic [WIDTH-1:0]        maddr,
  input  logic [WIDTH-1:0]        mwdata,
  output logic                    mready,
  output logic                    merr,
  output logic [WIDTH-1:0]        mrdata,
  output logic [NSLAVE-1:0]       ssel,
  output logic                    swrite,
  output logic [WIDTH-1:0]        saddr,
  output logic [WIDTH-1:0]        swdata,
  input  logic [NSLAVE-1:0]       sready,
  input  logic [NSLAVE*WIDTH-1:0] srdata
);

  localparam int RW = WIDTH - REGIONBITS;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [NSLAVE-1:0]  ssel_q, ssel_d;
  logic               swrite_q, swrite_d;
  logic [WIDTH-1:0]   saddr_q, saddr_d;
  logic [WIDTH-1:0]   swdata_q, swdata_d;
  logic               mready_q, mready_d;
  logic               merr_q, merr_d;
  logic [WIDTH-1:0]   mrdata_q, mrdata_d;

  logic [RW-1:0]      region;
  logic               hit;
  logic [NSLAVE-1:0]  onehot;
  logic               sel_ready;
  logic [WIDTH-1:0]   sel_rdata;
  logic [7:0]         cnt_inc;
  logic               timeout;

  // Address decode of the live master inputs; only used on the IDLE sample edge.
  always_comb begin
    region = maddr[WIDTH-1:REGIONBITS];
    hit    = 32'(region) < 32'(NSLAVE);
    onehot = '0;
    for (int i = 0; i < NSLAVE; i++) begin
      onehot[i] = (32'(region) == 32'(i));
    end
  end

  // The registered one-hot select masks out ready/data from every other slave.
  always_comb begin
    sel_ready = |(sready & ssel_q);
    sel_rdata = '0;
    for (int i = 0; i < NSLAVE; i++) begin
      if (ssel_q[i]) sel_rdata = sel_rdata | srdata[i*WIDTH +: WIDTH];
    end
  end

  // cnt_inc counts ACCESS cycles including the current one, so ACCESS lasts at most TIMEOUT cycles.
  always_comb begin
    cnt_inc = cnt_q + 8'd1;
    timeout = (cnt_inc == 8'(TIMEOUT));
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ssel_d   = ssel_q;
    swrite_d = swrite_q;
    saddr_d  = saddr_q;
    swdata_d = swdata_q;
    mready_d = 1'b0;
    merr_d   = 1'b0;
    mrdata_d = '0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (mreq) begin
          if (hit) begin
            state_d                    = ACCESS;
            ssel_d                     = onehot;
            swrite_d                   = mwrite;
            saddr_d                    = '0;
            saddr_d[REGIONBITS-1:0]    = maddr[REGIONBITS-1:0];
            swdata_d                   = mwdata;
          end else begin
            state_d  = RESP;
            mready_d = 1'b1;
            merr_d   = 1'b1;
          end
        end
      end
      ACCESS: begin
        cnt_d = cnt_inc;
        if (sel_ready || timeout) begin
          // Ready wins over a coincident timeout.
          state_d  = RESP;
          mready_d = 1'b1;
          merr_d   = !sel_ready;
          mrdata_d = (sel_ready && !swrite_q) ? sel_rdata : '0;
          ssel_d   = '0;
          swrite_d = 1'b0;
          saddr_d  = '0;
          swdata_d = '0;
        end
      end
      RESP: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        state_d  = IDLE;
        cnt_d    = '0;
        ssel_d   = '0;
        swrite_d = 1'b0;
        saddr_d  = '0;
        swdata_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ssel_q   <= '0;
      swrite_q <= 1'b0;
      saddr_q  <= '0;
      swdata_q <= '0;
      mready_q <= 1'b0;
      merr_q   <= 1'b0;
      mrdata_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ssel_q   <= ssel_d;
      swrite_q <= swrite_d;
      saddr_q  <= saddr_d;
      swdata_q <= swdata_d;
      mready_q <= mready_d;
      merr_q   <= merr_d;
      mrdata_q <= mrdata_d;
    end
  end

  assign ssel   = ssel_q;
  assign swrite = swrite_q;
  assign saddr  = saddr_q;
  assign swdata = swdata_q;
  assign mready = mready_q;
  assign merr   = merr_q;
  assign mrdata = mrdata_q;

endmodule

// File: tb/tb_sysbus_nslave.sv
// Bench for sysbus_nslave: vector table with a response scoreboard plus hand-written
// reset and back-to-back sequences. Inputs change and outputs are sampled on the falling edge.
module tb_sysbus_nslave;

  logic         clk = 1'b0;
  logic         nrst;
  logic         mreq;
  logic         mwrite;
  logic [31:0]  maddr;
  logic [31:0]  mwdata;
  logic         mready;
  logic         merr;
  logic [31:0]  mrdata;
  logic [3:0]   ssel;
  logic         swrite;
  logic [31:0]  saddr;
  logic [31:0]  swdata;
  logic [3:0]   sready;
  logic [127:0] srdata;

  sysbus_nslave #(.WIDTH(32), .NSLAVE(4), .REGIONBITS(20), .TIMEOUT(15)) dut (
    .clk(clk), .nrst(nrst), .mreq(mreq), .mwrite(mwrite), .maddr(maddr), .mwdata(mwdata),
    .mready(mready), .merr(merr), .mrdata(mrdata), .ssel(ssel), .swrite(swrite),
    .saddr(saddr), .swdata(swdata), .sready(sready), .srdata(srdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          slv;
    int          wt;
    logic [31:0] rdata;
    logic [3:0]  noise;
    logic [3:0]  e_ssel;
    logic [31:0] e_saddr;
    logic        e_merr;
    logic [31:0] e_rdata;
    int          e_lat;
    int          e_acc;
  } vec_t;

  typedef struct {
    logic        merr;
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  vec_t tbl[7];
  vec_t v6a, v6b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic drive_req(input vec_t v);
    mwrite = v.wr;
    maddr  = v.addr;
    mwdata = v.wdata;
    mreq   = 1'b1;
    for (int i = 0; i < 4; i++) srdata[i*32 +: 32] = ~v.rdata;
    srdata[v.slv*32 +: 32] = v.rdata;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ssel"},   32'(ssel),   32'd0);
    chk({tag, "_swrite"}, 32'(swrite), 32'd0);
    chk({tag, "_saddr"},  saddr,       32'd0);
    chk({tag, "_swdata"}, swdata,      32'd0);
    chk({tag, "_mready"}, 32'(mready), 32'd0);
    chk({tag, "_merr"},   32'(merr),   32'd0);
    chk({tag, "_mrdata"}, mrdata,      32'd0);
  endtask

  // pre: request was already presented at the previous mready; b2b: present nv at this mready.
  task automatic run_txn(input vec_t v, input bit pre, input bit b2b, input vec_t nv);
    exp_t e, got;
    int   cyc  = 0;
    int   acc  = 0;
    bit   done = 1'b0;
    e.merr  = v.e_merr;
    e.rdata = v.e_rdata;
    e.lat   = v.e_lat;
    exp_q.push_back(e);
    @(negedge clk);
    if (pre) begin
      chk("b2b_idle_ssel",   32'(ssel),   32'd0);
      chk("b2b_idle_mready", 32'(mready), 32'd0);
    end else begin
      drive_req(v);
    end
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (mready) begin
        done = 1'b1;
        if (exp_q.size() == 0) begin
          chk("sb_underflow", 32'(exp_q.size()), 32'd1);
        end else begin
          got = exp_q.pop_front();
          chk("merr",    32'(merr), 32'(got.merr));
          chk("mrdata",  mrdata,    got.rdata);
          chk("latency", cyc,       got.lat);
        end
        chk("access_cycles", acc,        v.e_acc);
        chk("resp_ssel",     32'(ssel),  32'd0);
        chk("resp_swrite",   32'(swrite),32'd0);
        sready = v.noise;
        if (b2b) drive_req(nv);
        else     mreq = 1'b0;
      end else begin
        if (ssel != 4'b0000) begin
          acc++;
          chk("ssel",   32'(ssel),   32'(v.e_ssel));
          chk("saddr",  saddr,       v.e_saddr);
          chk("swrite", 32'(swrite), 32'(v.wr));
          if (v.wr) chk("swdata", swdata, v.wdata);
        end
        if (cyc == 1) begin
          maddr  = 32'hFFFF_FFFC;
          mwdata = ~v.wdata;
          mwrite = ~v.wr;
        end
        sready = v.noise | ((ssel != 4'b0000 && acc == v.wt + 1) ? (4'b0001 << v.slv) : 4'b0000);
      end
    end
    chk("mready_seen", 32'(done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = '{wr:1'b0, addr:32'h0010_0040, wdata:32'h0, slv:1, wt:0, rdata:32'hDEAD_BEEF, noise:4'b0000,
               e_ssel:4'b0010, e_saddr:32'h40, e_merr:1'b0, e_rdata:32'hDEAD_BEEF, e_lat:2, e_acc:1};
    tbl[1] = '{wr:1'b1, addr:32'h0000_0004, wdata:32'h1234, slv:0, wt:3, rdata:32'hCAFE_F00D, noise:4'b0000,
               e_ssel:4'b0001, e_saddr:32'h4, e_merr:1'b0, e_rdata:32'h0, e_lat:5, e_acc:4};
    tbl[2] = '{wr:1'b0, addr:32'h0050_0000, wdata:32'h0, slv:0, wt:0, rdata:32'h1111_2222, noise:4'b0000,
               e_ssel:4'b0000, e_saddr:32'h0, e_merr:1'b1, e_rdata:32'h0, e_lat:1, e_acc:0};
    tbl[3] = '{wr:1'b0, addr:32'h0020_0ABC, wdata:32'h0, slv:2, wt:255, rdata:32'h7777_8888, noise:4'b0000,
               e_ssel:4'b0100, e_saddr:32'hABC, e_merr:1'b1, e_rdata:32'h0, e_lat:16, e_acc:15};
    tbl[4] = '{wr:1'b0, addr:32'h003F_FFFC, wdata:32'h0, slv:3, wt:2, rdata:32'hA5A5_5A5A, noise:4'b0001,
               e_ssel:4'b1000, e_saddr:32'hF_FFFC, e_merr:1'b0, e_rdata:32'hA5A5_5A5A, e_lat:4, e_acc:3};
    tbl[5] = '{wr:1'b1, addr:32'hFFF0_0000, wdata:32'h9999, slv:0, wt:0, rdata:32'h3333_4444, noise:4'b0000,
               e_ssel:4'b0000, e_saddr:32'h0, e_merr:1'b1, e_rdata:32'h0, e_lat:1, e_acc:0};
    tbl[6] = '{wr:1'b0, addr:32'h0020_0000, wdata:32'h0, slv:2, wt:14, rdata:32'h0BAD_F00D, noise:4'b0000,
               e_ssel:4'b0100, e_saddr:32'h0, e_merr:1'b0, e_rdata:32'h0BAD_F00D, e_lat:16, e_acc:15};
    v6a = '{wr:1'b0, addr:32'h0000_0100, wdata:32'h0, slv:0, wt:14, rdata:32'h600D_CAFE, noise:4'b1000,
            e_ssel:4'b0001, e_saddr:32'h100, e_merr:1'b0, e_rdata:32'h600D_CAFE, e_lat:16, e_acc:15};
    v6b = '{wr:1'b1, addr:32'h0030_0008, wdata:32'h55AA, slv:3, wt:0, rdata:32'h1357_9BDF, noise:4'b0000,
            e_ssel:4'b1000, e_saddr:32'h8, e_merr:1'b0, e_rdata:32'h0, e_lat:2, e_acc:1};

    nrst = 1'b0; mreq = 1'b0; mwrite = 1'b0; maddr = '0; mwdata = '0; sready = '0; srdata = '0;
    @(negedge clk);
    @(negedge clk);
    chk_all_zero("rst");
    nrst = 1'b1;

    // Reset in the middle of an ACCESS aborts the transaction silently.
    @(negedge clk);
    drive_req(tbl[3]);
    @(negedge clk);
    chk("rst_pre_ssel", 32'(ssel), 32'h4);
    mreq = 1'b0;
    @(negedge clk);
    nrst = 1'b0;
    @(negedge clk);
    chk_all_zero("midrst1");
    @(negedge clk);
    chk_all_zero("midrst2");
    nrst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("postrst_mready", 32'(mready), 32'd0);
      chk("postrst_ssel",   32'(ssel),   32'd0);
    end

    for (int i = 0; i < 7; i++) run_txn(tbl[i], 1'b0, 1'b0, tbl[i]);

    // Wrong-slave noise, ready on the timeout cycle, then an immediate second request.
    run_txn(v6a, 1'b0, 1'b1, v6b);
    run_txn(v6b, 1'b1, 1'b0, v6b);

    @(negedge clk);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    chk("idle_mready", 32'(mready), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
